// File: rtl/shift_reg_seq.sv
// Shift unit for the multicycle MIPS datapath: load/SLL/SRL/SRA/ROR/ROL with a busy/done handshake.
// Define SHIFT_REG_BARREL_EN for a single-cycle barrel shifter; by default the unit moves one bit per clock.
module shift_reg_seq #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        shift_op,
    input  logic [31:0]       shift_amt_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_SRA  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

`ifdef SHIFT_REG_BARREL_EN
    localparam state_t ST_WORK = ST_DONE;
`else
    localparam state_t ST_WORK = ST_SHIFT;
`endif

    state_t            state_r, state_next_s;
    logic [DATA_W-1:0] data_r, data_next_s;
    logic [AMT_W-1:0]  cnt_r, cnt_next_s;
    logic [2:0]        op_r, op_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic [AMT_W-1:0]  amt_s;
    logic [2:0]        op_norm_s;
    logic              amt_unused_s;

    // Single-position step used by the iterative engine
    function automatic logic [DATA_W-1:0] step_one(input logic [2:0] op, input logic [DATA_W-1:0] d);
        case (op)
            OP_SLL:  return {d[DATA_W-2:0], 1'b0};
            OP_SRL:  return {1'b0, d[DATA_W-1:1]};
            OP_SRA:  return {d[DATA_W-1], d[DATA_W-1:1]};
            OP_ROR:  return {d[0], d[DATA_W-1:1]};
            OP_ROL:  return {d[DATA_W-2:0], d[DATA_W-1]};
            default: return d;
        endcase
    endfunction

`ifdef SHIFT_REG_BARREL_EN
    // Full-distance shift; rotates are taken from a doubled copy of the operand
    function automatic logic [DATA_W-1:0] shift_full(input logic [2:0] op, input logic [DATA_W-1:0] d,
                                                     input logic [AMT_W-1:0] amt);
        logic [2*DATA_W-1:0] dbl_r, dbl_l;
        dbl_r = {d, d} >> amt;
        dbl_l = {d, d} << amt;
        case (op)
            OP_SLL:  return d << amt;
            OP_SRL:  return d >> amt;
            OP_SRA:  return $unsigned($signed(d) >>> amt);
            OP_ROR:  return dbl_r[DATA_W-1:0];
            OP_ROL:  return dbl_l[2*DATA_W-1:DATA_W];
            default: return d;
        endcase
    endfunction
`endif

    assign amt_s        = shift_amt_in[AMT_W-1:0];
    assign amt_unused_s = ^shift_amt_in[31:AMT_W];
    assign op_norm_s    = (shift_op > OP_ROL) ? OP_LOAD : shift_op;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((amt_s == CNT_ZERO) || (op_norm_s == OP_LOAD)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_WORK;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r <= CNT_ONE) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and handshake next values; flags are derived from the next state so they are registered
    always_comb begin
        data_next_s = data_r;
        cnt_next_s  = cnt_r;
        op_next_s   = op_r;
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_next_s == ST_DONE);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
`ifdef SHIFT_REG_BARREL_EN
                    data_next_s = shift_full(op_norm_s, data_in, amt_s);
`else
                    data_next_s = data_in;
`endif
                    cnt_next_s  = amt_s;
                    op_next_s   = op_norm_s;
                end else begin
                    data_next_s = data_r;
                end
            end
            ST_SHIFT: begin
                data_next_s = step_one(op_r, data_r);
                cnt_next_s  = cnt_r - CNT_ONE;
            end
            ST_DONE: data_next_s = data_r;
            default: data_next_s = data_r;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r <= '0;
            cnt_r  <= '0;
            op_r   <= OP_LOAD;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            data_r <= data_next_s;
            cnt_r  <= cnt_next_s;
            op_r   <= op_next_s;
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign data_out = data_r;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed, table-driven bench for shift_reg_seq; latency expectations follow SHIFT_REG_BARREL_EN.
module tb_shift_reg_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  shift_op = 3'd0;
    logic [31:0] shift_amt_in = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic        busy, done;
    logic [31:0] data_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] amt;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    shift_reg_seq dut (
        .clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
        .shift_amt_in(shift_amt_in), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] amt);
        int l;
        l = int'(amt[4:0]);
        if (op == 3'd0 || op > 3'd5) l = 0;
`ifdef SHIFT_REG_BARREL_EN
        l = 0;
`endif
        return l;
    endfunction

    // Counts falling edges after E0 until done; optionally disturbs inputs while busy
    task automatic wait_done(output int n, output int busy_cnt, input bit interfere);
        n = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (interfere && i == 0) begin
                start = 1'b1;
                data_in = 32'hA5A5_A5A5;
                shift_op = 3'd1;
                shift_amt_in = 32'd7;
            end
            if (interfere && i == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] amt,
                          input logic [31:0] din, input logic [31:0] exp, input bit interfere);
        int n, bc, l;
        l = exp_lat(op, amt);
        @(negedge clk);
        start = 1'b1;
        shift_op = op;
        shift_amt_in = amt;
        data_in = din;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bc, interfere);
        chk({name, " latency"}, 32'(n), 32'(l));
        chk({name, " busy cycles"}, 32'(bc), 32'(l + 1));
        chk({name, " result"}, data_out, exp);
        @(negedge clk);
        start = 1'b0;
        chk({name, " idle busy"}, {31'd0, busy}, 32'd0);
        chk({name, " idle done"}, {31'd0, done}, 32'd0);
        chk({name, " hold"}, data_out, exp);
    endtask

    initial begin
        int n, bc, pulses;

        vecs[0]  = '{"sll4",      3'd1, 32'd4,          32'h0000_0001, 32'h0000_0010};
        vecs[1]  = '{"sra31",     3'd3, 32'd31,         32'h8000_0000, 32'hFFFF_FFFF};
        vecs[2]  = '{"srl31",     3'd2, 32'd31,         32'h8000_0000, 32'h0000_0001};
        vecs[3]  = '{"ror1",      3'd4, 32'd1,          32'h8000_0001, 32'hC000_0000};
        vecs[4]  = '{"rol1",      3'd5, 32'd1,          32'h8000_0001, 32'h0000_0003};
        vecs[5]  = '{"wrap32",    3'd1, 32'h0000_0020,  32'h1234_5678, 32'h1234_5678};
        vecs[6]  = '{"op110",     3'd6, 32'd5,          32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7]  = '{"amt0x123",  3'd1, 32'h0000_0123,  32'h0000_0001, 32'h0000_0008};
        vecs[8]  = '{"rol4",      3'd5, 32'd4,          32'h1234_5678, 32'h2345_6781};
        vecs[9]  = '{"ror8",      3'd4, 32'd8,          32'h1234_5678, 32'h7812_3456};
        vecs[10] = '{"sra3pos",   3'd3, 32'd3,          32'h4000_0000, 32'h0800_0000};
        vecs[11] = '{"op111",     3'd7, 32'd0,          32'h0F0F_0F0F, 32'h0F0F_0F0F};

        // Reset state
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset data", data_out, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp, 1'b0);
        end

        // Start pulse and input changes while busy must not disturb the in-flight op
        run_op("interfere", 3'd2, 32'd4, 32'hF000_0000, 32'h0F00_0000, 1'b1);

        // Reset mid-SHIFT aborts immediately without a done pulse
        @(negedge clk);
        start = 1'b1;
        shift_op = 3'd1;
        shift_amt_in = 32'd10;
        data_in = 32'h0000_0001;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort data", data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort no done", 32'(pulses), 32'd0);
        run_op("post-reset sll1", 3'd1, 32'd1, 32'h0000_0001, 32'h0000_0002, 1'b0);

        // start held high: second op accepted after exactly one IDLE cycle
        @(negedge clk);
        start = 1'b1;
        shift_op = 3'd1;
        shift_amt_in = 32'd2;
        data_in = 32'h0000_0001;
        wait_done(n, bc, 1'b0);
        chk("held op1 latency", 32'(n), 32'(exp_lat(3'd1, 32'd2)));
        chk("held op1 result", data_out, 32'h0000_0004);
        shift_op = 3'd5;
        shift_amt_in = 32'd1;
        data_in = 32'h8000_0000;
        @(negedge clk);
        chk("held gap busy", {31'd0, busy}, 32'd0);
        chk("held gap done", {31'd0, done}, 32'd0);
        wait_done(n, bc, 1'b0);
        start = 1'b0;
        chk("held op2 latency", 32'(n), 32'(exp_lat(3'd5, 32'd1)));
        chk("held op2 result", data_out, 32'h0000_0001);
        @(negedge clk);
        chk("held final idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
